// File: rtl/sd_pkg.sv
// Shared constants and state encoding for the SD 4-bit data transmit path.
package sd_pkg;

  localparam int unsigned MAX_BYTES = 512;
  localparam int unsigned CRC_BITS  = 16;
  localparam logic [CRC_BITS-1:0] CRC_POLY = 16'h1021;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_DATA,
    ST_CRC,
    ST_END,
    ST_RELEASE
  } tx_state_t;

endpackage

// File: rtl/sd_crc16.sv
// Serial CRC-16 (x^16+x^12+x^5+1) for one DAT line; no reset, cleared per block.
module sd_crc16
  import sd_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_clear,
  input  logic                i_en,
  input  logic                i_bit,
  output logic [CRC_BITS-1:0] o_crc
);

  logic [CRC_BITS-1:0] r_crc;
  logic                w_fb;

  assign w_fb  = i_bit ^ r_crc[CRC_BITS-1];
  assign o_crc = r_crc;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= {r_crc[CRC_BITS-2:0], 1'b0} ^ (w_fb ? CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/sd_data_tx_ctrl.sv
// SD 4-bit block transmitter: start bit, nibble data, per-line CRC16, end bit.
module sd_data_tx_ctrl
  import sd_pkg::*;
#(
  parameter int unsigned MAX_BYTES = sd_pkg::MAX_BYTES
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       sd_tick,
  input  logic       start,
  input  logic [9:0] block_len,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [3:0] dat_out,
  output logic       dat_oe,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int unsigned NIB_W = $clog2(2 * MAX_BYTES + 1);

  tx_state_t         r_state, w_state_nx;
  logic [NIB_W-1:0]  r_nib, w_nib_nx, w_start_nib;
  logic [3:0]        r_cnt, w_cnt_nx;
  logic [7:0]        r_hold, w_hold_nx, w_byte;
  logic              r_full, w_full_nx;
  logic [3:0]        r_low, w_low_nx;
  logic [3:0]        r_dat, w_dat_nx;
  logic              r_oe, w_oe_nx;
  logic              r_done, w_done_nx;
  logic              r_und, w_und_nx;
  logic              r_abort, w_abort_nx;
  logic              w_ready, w_take, w_have;
  logic              w_crc_clr, w_crc_en;
  logic [3:0]        w_crc_in, w_msb;
  logic [CRC_BITS-1:0] w_crc [4];

  for (genvar g = 0; g < 4; g++) begin : g_crc
    sd_crc16 u_crc (
      .i_clk   (clock),
      .i_clear (w_crc_clr),
      .i_en    (w_crc_en),
      .i_bit   (w_crc_in[g]),
      .o_crc   (w_crc[g])
    );
    assign w_msb[g] = w_crc[g][CRC_BITS-1];
  end

  assign w_start_nib = (block_len == '0) ? NIB_W'(2 * MAX_BYTES) : NIB_W'({block_len, 1'b0});

  // Fetch only while bytes remain, so no byte past the block is swallowed.
  assign w_ready = ((r_state == ST_ARM) || ((r_state == ST_DATA) && (r_nib > NIB_W'(1)))) && !r_full;
  assign w_take  = w_ready && data_valid;
  assign w_have  = r_full || w_take;
  assign w_byte  = r_full ? r_hold : data;

  always_comb begin
    w_state_nx = r_state;
    w_nib_nx   = r_nib;
    w_cnt_nx   = r_cnt;
    w_hold_nx  = r_hold;
    w_full_nx  = r_full;
    w_low_nx   = r_low;
    w_dat_nx   = r_dat;
    w_oe_nx    = r_oe;
    w_done_nx  = 1'b0;
    w_und_nx   = 1'b0;
    w_abort_nx = r_abort;
    w_crc_clr  = 1'b0;
    w_crc_en   = 1'b0;
    w_crc_in   = '0;

    if (w_take) begin
      w_hold_nx = data;
      w_full_nx = 1'b1;
    end

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nx = ST_ARM;
          w_nib_nx   = w_start_nib;
          w_cnt_nx   = '0;
          w_full_nx  = 1'b0;
          w_abort_nx = 1'b0;
        end
      end
      ST_ARM: begin
        if (sd_tick) begin
          w_dat_nx   = '0;
          w_oe_nx    = 1'b1;
          w_crc_clr  = 1'b1;
          w_state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        if (sd_tick) begin
          if (!r_nib[0]) begin
            if (w_have) begin
              w_dat_nx  = w_byte[7:4];
              w_low_nx  = w_byte[3:0];
              w_full_nx = 1'b0;
              w_crc_en  = 1'b1;
              w_crc_in  = w_byte[7:4];
              w_nib_nx  = r_nib - NIB_W'(1);
            end else begin
              w_dat_nx   = '1;
              w_done_nx  = 1'b1;
              w_und_nx   = 1'b1;
              w_abort_nx = 1'b1;
              w_state_nx = ST_RELEASE;
            end
          end else begin
            w_dat_nx = r_low;
            w_crc_en = 1'b1;
            w_crc_in = r_low;
            w_nib_nx = r_nib - NIB_W'(1);
            if (r_nib == NIB_W'(1)) begin
              w_state_nx = ST_CRC;
              w_cnt_nx   = 4'd15;
            end
          end
        end
      end
      ST_CRC: begin
        // Feeding each unit its own MSB cancels the feedback: a plain left shift.
        if (sd_tick) begin
          w_dat_nx = w_msb;
          w_crc_en = 1'b1;
          w_crc_in = w_msb;
          w_cnt_nx = r_cnt - 4'd1;
          if (r_cnt == 4'd0) begin
            w_state_nx = ST_END;
          end
        end
      end
      ST_END: begin
        if (sd_tick) begin
          w_dat_nx   = '1;
          w_state_nx = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (sd_tick) begin
          w_dat_nx   = '1;
          w_oe_nx    = 1'b0;
          w_done_nx  = !r_abort;
          w_state_nx = ST_IDLE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_nib   <= '0;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_full  <= 1'b0;
      r_low   <= '0;
      r_dat   <= '1;
      r_oe    <= 1'b0;
      r_done  <= 1'b0;
      r_und   <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_nib   <= w_nib_nx;
      r_cnt   <= w_cnt_nx;
      r_hold  <= w_hold_nx;
      r_full  <= w_full_nx;
      r_low   <= w_low_nx;
      r_dat   <= w_dat_nx;
      r_oe    <= w_oe_nx;
      r_done  <= w_done_nx;
      r_und   <= w_und_nx;
      r_abort <= w_abort_nx;
    end
  end

  assign data_ready = w_ready;
  assign dat_out    = r_dat;
  assign dat_oe     = r_oe;
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign underrun   = r_und;

endmodule

// File: tb/tb_sd_data_tx_ctrl.sv
// Directed bench for sd_data_tx_ctrl: per-tick DAT capture against a CRC model.
module tb_sd_data_tx_ctrl;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       sd_tick;
  logic       start;
  logic [9:0] block_len;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic [3:0] dat_out;
  logic       dat_oe;
  logic       busy;
  logic       done;
  logic       underrun;

  int total = 0;
  int bad   = 0;

  logic [7:0] src_q[$];
  int         src_cnt = 0;
  logic       src_en  = 1'b0;
  logic       stall_en = 1'b0;
  logic       stall_r  = 1'b0;
  logic       hs = 1'b0;

  logic [3:0] cap_dat[$];
  logic       cap_oe[$];
  logic       cap_done[$];
  logic       cap_und[$];
  logic [3:0] exp_dat[$];
  logic       exp_oe[$];
  logic [7:0] exp_bytes[$];

  sd_data_tx_ctrl #(.MAX_BYTES(512)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .sd_tick    (sd_tick),
    .start      (start),
    .block_len  (block_len),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .dat_out    (dat_out),
    .dat_oe     (dat_oe),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  always #5 clock = ~clock;

  // Byte source: stalls randomly when enabled, but always offers data on a tick cycle.
  assign data_valid = src_en && (src_cnt != 0) && (!stall_r || sd_tick);

  always @(posedge clock) hs <= data_valid && data_ready;

  always @(negedge clock) begin
    if (hs && src_q.size() > 0) void'(src_q.pop_front());
    src_cnt = src_q.size();
    data    = (src_cnt != 0) ? src_q[0] : 8'h00;
    stall_r = stall_en && ($urandom_range(0, 1) == 1);
  end

  function automatic logic [15:0] line_crc(input int line);
    logic [16:0] r;
    r = '0;
    foreach (exp_bytes[k]) begin
      for (int h = 1; h >= 0; h--) begin
        r = {r[15:0], exp_bytes[k][4*h + line]};
        if (r[16]) r = r ^ 17'h11021;
      end
    end
    for (int z = 0; z < 16; z++) begin
      r = {r[15:0], 1'b0};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  task automatic build_exp();
    logic [15:0] crc_ln [4];
    logic [3:0]  d;
    exp_dat.delete();
    exp_oe.delete();
    exp_oe.push_back(1'b1); exp_dat.push_back(4'h0);
    foreach (exp_bytes[k]) begin
      exp_oe.push_back(1'b1); exp_dat.push_back(exp_bytes[k][7:4]);
      exp_oe.push_back(1'b1); exp_dat.push_back(exp_bytes[k][3:0]);
    end
    for (int i = 0; i < 4; i++) crc_ln[i] = line_crc(i);
    for (int b = 15; b >= 0; b--) begin
      for (int i = 0; i < 4; i++) d[i] = crc_ln[i][b];
      exp_oe.push_back(1'b1); exp_dat.push_back(d);
    end
    exp_oe.push_back(1'b1); exp_dat.push_back(4'hF);
    exp_oe.push_back(1'b0); exp_dat.push_back(4'hF);
  endtask

  function automatic int first_diff();
    int n;
    n = (cap_dat.size() < exp_dat.size()) ? cap_dat.size() : exp_dat.size();
    for (int k = 0; k < n; k++)
      if (cap_dat[k] !== exp_dat[k] || cap_oe[k] !== exp_oe[k]) return k;
    if (cap_dat.size() != exp_dat.size()) return n;
    return -1;
  endfunction

  task automatic tick(input int gap);
    repeat (gap) @(negedge clock);
    sd_tick = 1'b1;
    @(negedge clock);
    sd_tick = 1'b0;
  endtask

  task automatic flush();
    src_en   = 1'b0;
    stall_en = 1'b0;
    src_q.delete();
    repeat (2) @(negedge clock);
  endtask

  task automatic load_and_start(input logic [9:0] len);
    src_q    = exp_bytes;
    src_en   = 1'b1;
    @(negedge clock);
    start     = 1'b1;
    block_len = len;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run_ticks(input int gap, input int max_ticks, input int start_at, output bit ended);
    cap_dat.delete(); cap_oe.delete(); cap_done.delete(); cap_und.delete();
    ended = 1'b0;
    for (int n = 0; n < max_ticks; n++) begin
      if (n == start_at) begin
        start     = 1'b1;
        block_len = 10'd5;
      end
      tick(gap);
      start = 1'b0;
      cap_oe.push_back(dat_oe);
      cap_dat.push_back(dat_out);
      cap_done.push_back(done);
      cap_und.push_back(underrun);
      if (!busy) begin
        ended = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [8:0] v;
    v = {dat_oe, dat_out, busy, data_ready, done, underrun};
    total++;
    if (v !== 9'b0_1111_0000) begin
      bad++;
      $display("FAIL reset_outputs: got %b want %b", v, 9'b0_1111_0000);
    end
    rst_n = 1'b1;
    @(negedge clock);
    v = {dat_oe, dat_out, busy, data_ready, done, underrun};
    total++;
    if (v !== 9'b0_1111_0000) begin
      bad++;
      $display("FAIL idle_after_reset: got %b want %b", v, 9'b0_1111_0000);
    end
  endtask

  task automatic test_full_block();
    bit ended;
    int idx, nd, nu;
    exp_bytes.delete();
    for (int k = 0; k < 512; k++) exp_bytes.push_back(8'hFF);
    build_exp();
    load_and_start(10'd0);
    total++;
    if ({busy, data_ready} !== 2'b11) begin
      bad++;
      $display("FAIL full_arm_ready: got %b want 11", {busy, data_ready});
    end
    run_ticks(0, 1100, -1, ended);
    total++;
    if (ended !== 1'b1) begin bad++; $display("FAIL full_timeout: got ended=%0d want 1", ended); end
    total++;
    if (cap_dat.size() != 1043) begin
      bad++;
      $display("FAIL full_tick_count: got %0d want 1043", cap_dat.size());
    end
    idx = first_diff();
    total++;
    if (idx != -1) begin
      bad++;
      $display("FAIL full_wave: got first diff at tick %0d want none", idx);
    end
    nd = 0; nu = 0;
    foreach (cap_done[k]) begin nd += int'(cap_done[k]); nu += int'(cap_und[k]); end
    total++;
    if (nd != 1 || cap_done[cap_done.size()-1] !== 1'b1 || nu != 0) begin
      bad++;
      $display("FAIL full_done: got done=%0d underrun=%0d want done=1 (last) underrun=0", nd, nu);
    end
    flush();
  endtask

  task automatic test_single_byte();
    bit ended;
    int idx, noe;
    exp_bytes.delete();
    exp_bytes.push_back(8'hA5);
    build_exp();
    load_and_start(10'd1);
    run_ticks(0, 40, -1, ended);
    idx = first_diff();
    total++;
    if (!ended || idx != -1) begin
      bad++;
      $display("FAIL single_wave: got ended=%0d diff=%0d want ended=1 diff=-1", ended, idx);
    end
    total++;
    if (cap_dat.size() < 3 || {cap_dat[1], cap_dat[2]} !== 8'hA5) begin
      bad++;
      $display("FAIL single_nibbles: got %h%h want a5", cap_dat[1], cap_dat[2]);
    end
    noe = 0;
    foreach (cap_oe[k]) noe += int'(cap_oe[k]);
    total++;
    if (noe != 20) begin bad++; $display("FAIL single_oe_ticks: got %0d want 20", noe); end
    total++;
    if ({busy, data_ready, dat_oe} !== 3'b000) begin
      bad++;
      $display("FAIL single_idle: got %b want 000", {busy, data_ready, dat_oe});
    end
    flush();
  endtask

  task automatic test_underrun();
    bit ended;
    int idx;
    exp_bytes.delete();
    exp_bytes.push_back(8'h12);
    exp_bytes.push_back(8'h34);
    exp_bytes.push_back(8'h56);
    build_exp();
    load_and_start(10'd8);
    run_ticks(0, 40, -1, ended);
    total++;
    if (!ended || cap_dat.size() != 9) begin
      bad++;
      $display("FAIL underrun_len: got ended=%0d ticks=%0d want 1 9", ended, cap_dat.size());
    end
    idx = -1;
    for (int k = 0; k < 7 && k < cap_dat.size(); k++)
      if (idx == -1 && (cap_dat[k] !== exp_dat[k] || cap_oe[k] !== exp_oe[k])) idx = k;
    total++;
    if (idx != -1) begin bad++; $display("FAIL underrun_prefix: got diff at %0d want none", idx); end
    if (cap_dat.size() >= 9) begin
      total++;
      if ({cap_oe[7], cap_dat[7], cap_done[7], cap_und[7]} !== 7'b1_1111_11) begin
        bad++;
        $display("FAIL underrun_abort: got %b want 1111111", {cap_oe[7], cap_dat[7], cap_done[7], cap_und[7]});
      end
      total++;
      if ({cap_oe[8], cap_dat[8], cap_done[8], cap_und[8]} !== 7'b0_1111_00) begin
        bad++;
        $display("FAIL underrun_release: got %b want 0111100", {cap_oe[8], cap_dat[8], cap_done[8], cap_und[8]});
      end
    end
    flush();
  endtask

  task automatic test_start_ignored();
    bit ended;
    int idx;
    exp_bytes.delete();
    exp_bytes.push_back(8'h3C);
    exp_bytes.push_back(8'hC3);
    build_exp();
    load_and_start(10'd2);
    run_ticks(0, 40, 3, ended);
    idx = first_diff();
    total++;
    if (!ended || idx != -1) begin
      bad++;
      $display("FAIL start_ignored: got ended=%0d diff=%0d want ended=1 diff=-1", ended, idx);
    end
    flush();
  endtask

  task automatic test_reset_mid_crc();
    bit ended;
    int idx;
    logic [8:0] v;
    exp_bytes.delete();
    exp_bytes.push_back(8'h0F);
    build_exp();
    load_and_start(10'd1);
    for (int n = 0; n < 8; n++) tick(0);
    total++;
    if ({busy, dat_oe} !== 2'b11) begin
      bad++;
      $display("FAIL mid_crc_active: got %b want 11", {busy, dat_oe});
    end
    #2 rst_n = 1'b0;
    #1 v = {dat_oe, dat_out, busy, data_ready, done, underrun};
    total++;
    if (v !== 9'b0_1111_0000) begin
      bad++;
      $display("FAIL async_reset: got %b want %b", v, 9'b0_1111_0000);
    end
    @(negedge clock);
    rst_n = 1'b1;
    flush();
    exp_bytes.delete();
    exp_bytes.push_back(8'h81);
    build_exp();
    load_and_start(10'd1);
    run_ticks(0, 40, -1, ended);
    idx = first_diff();
    total++;
    if (!ended || idx != -1) begin
      bad++;
      $display("FAIL after_reset_block: got ended=%0d diff=%0d want ended=1 diff=-1", ended, idx);
    end
    flush();
  endtask

  task automatic test_paced_stall();
    bit ended;
    int idx;
    logic [3:0] ref_dat[$];
    logic       ref_oe[$];
    exp_bytes.delete();
    exp_bytes.push_back(8'h01);
    exp_bytes.push_back(8'hEF);
    exp_bytes.push_back(8'h9A);
    exp_bytes.push_back(8'h70);
    exp_bytes.push_back(8'hB6);
    exp_bytes.push_back(8'h2D);
    build_exp();
    load_and_start(10'd6);
    run_ticks(0, 60, -1, ended);
    idx = first_diff();
    total++;
    if (!ended || idx != -1) begin
      bad++;
      $display("FAIL paced_ref_wave: got ended=%0d diff=%0d want ended=1 diff=-1", ended, idx);
    end
    ref_dat = cap_dat;
    ref_oe  = cap_oe;
    flush();
    stall_en = 1'b1;
    load_and_start(10'd6);
    stall_en = 1'b1;
    run_ticks(2, 60, -1, ended);
    idx = (cap_dat.size() == ref_dat.size()) ? -1 : 0;
    for (int k = 0; k < cap_dat.size() && k < ref_dat.size(); k++)
      if (idx == -1 && (cap_dat[k] !== ref_dat[k] || cap_oe[k] !== ref_oe[k])) idx = k;
    total++;
    if (!ended || idx != -1) begin
      bad++;
      $display("FAIL paced_vs_continuous: got ended=%0d diff=%0d want ended=1 diff=-1", ended, idx);
    end
    flush();
  endtask

  initial begin
    rst_n     = 1'b1;
    sd_tick   = 1'b0;
    start     = 1'b0;
    block_len = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clock);
    test_reset();
    test_full_block();
    test_single_byte();
    test_underrun();
    test_start_ignored();
    test_reset_mid_crc();
    test_paced_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
